// File: rtl/mac_operand_feeder_pkg.sv
// Shared definitions for the CNN MAC operand feeder slice.
// Operand/address defaults, FSM encodings and the sideband bundle.
package mac_operand_feeder_pkg;

    localparam int DEF_DATA_W = 9;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_TAPS   = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } sb_t;

    localparam sb_t SB_NONE = '0;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Job control, ROM port pair and MAC operand stream of the feeder.
// master = feeder side, slave = job issuer / ROMs / MAC side.
interface mac_operand_feeder_if
    import mac_operand_feeder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic                     start;
    logic [ADDR_W-1:0]        base_a;
    logic [ADDR_W-1:0]        base_b;
    logic [7:0]               n_out;
    logic                     busy;
    logic                     done;

    logic                     rd_en;
    logic [ADDR_W-1:0]        addr_a;
    logic [ADDR_W-1:0]        addr_b;
    logic signed [DATA_W-1:0] rdata_a;
    logic signed [DATA_W-1:0] rdata_b;

    logic signed [DATA_W-1:0] mac_dataa;
    logic signed [DATA_W-1:0] mac_datab;
    logic                     mac_valid;
    logic                     mac_first;
    logic                     mac_last;

    modport master (
        input  start, base_a, base_b, n_out,
        input  rdata_a, rdata_b,
        output busy, done,
        output rd_en, addr_a, addr_b,
        output mac_dataa, mac_datab,
        output mac_valid, mac_first, mac_last
    );

    modport slave (
        output start, base_a, base_b, n_out,
        output rdata_a, rdata_b,
        input  busy, done,
        input  rd_en, addr_a, addr_b,
        input  mac_dataa, mac_datab,
        input  mac_valid, mac_first, mac_last
    );

endinterface

// File: rtl/mac_operand_feeder_sideband_delay.sv
// Depth-N shift register carrying {valid,first,last} alongside ROM data.
// pre_valid taps the stage before the output to time the data capture.
module sideband_delay
    import mac_operand_feeder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rstn,
    input  sb_t  d,
    output sb_t  q,
    output logic pre_valid
);

    sb_t pipe [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= SB_NONE;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

    generate
        if (DEPTH > 1) begin : g_tap
            assign pre_valid = pipe[DEPTH-2].valid;
        end else begin : g_direct
            assign pre_valid = d.valid;
        end
    endgenerate

endmodule

// File: rtl/mac_operand_feeder.sv
// Sequencer walking activation/weight ROMs and streaming operand pairs
// with first/last markers into the signed MULT_ACCUM stage.
module mac_operand_feeder
    import mac_operand_feeder_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TAPS    = DEF_TAPS,
    parameter int STRIDE  = 1,
    parameter int ROM_LAT = 1
) (
    input logic                 clk,
    input logic                 rstn,
    mac_operand_feeder_if.master bus
);

    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int DW = $clog2(ROM_LAT + 1) + 1;

    localparam logic [TW-1:0]     T_LAST = TW'(TAPS - 1);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(STRIDE);
    localparam logic [DW-1:0]     D_INIT = DW'(ROM_LAT);

    logic [1:0]        state;
    logic [TW-1:0]     tap;
    logic [7:0]        outn;
    logic [7:0]        n_r;
    logic [ADDR_W-1:0] off_a;
    logic [ADDR_W-1:0] base_a_r;
    logic [ADDR_W-1:0] base_b_r;
    logic [DW-1:0]     drain;

    logic              rd_en_r;
    logic [ADDR_W-1:0] addr_a_r;
    logic [ADDR_W-1:0] addr_b_r;

    logic signed [DATA_W-1:0] data_a_r;
    logic signed [DATA_W-1:0] data_b_r;

    logic              tap_end;
    logic              out_end;
    logic [TW-1:0]     tap_nxt;
    logic [ADDR_W-1:0] off_nxt;

    sb_t  issue;
    sb_t  sb_q;
    logic cap;

    assign tap_end = (tap == T_LAST);
    assign out_end = (outn == n_r - 8'd1);
    assign tap_nxt = tap_end ? '0 : tap + TW'(1);
    // o*STRIDE is carried as a running offset bumped once per output
    assign off_nxt = tap_end ? off_a + STEP : off_a;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            tap      <= '0;
            outn     <= '0;
            n_r      <= '0;
            off_a    <= '0;
            base_a_r <= '0;
            base_b_r <= '0;
            drain    <= '0;
            rd_en_r  <= 1'b0;
            addr_a_r <= '0;
            addr_b_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        base_a_r <= bus.base_a;
                        base_b_r <= bus.base_b;
                        n_r      <= bus.n_out;
                        tap      <= '0;
                        outn     <= '0;
                        off_a    <= '0;
                        addr_a_r <= bus.base_a;
                        addr_b_r <= bus.base_b;
                        if (bus.n_out != 8'd0) begin
                            state   <= ST_RUN;
                            rd_en_r <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (tap_end && out_end) begin
                        state   <= ST_DRAIN;
                        rd_en_r <= 1'b0;
                        drain   <= D_INIT;
                    end else begin
                        tap      <= tap_nxt;
                        off_a    <= off_nxt;
                        outn     <= tap_end ? outn + 8'd1 : outn;
                        addr_a_r <= base_a_r + off_nxt + ADDR_W'(tap_nxt);
                        addr_b_r <= base_b_r + ADDR_W'(tap_nxt);
                    end
                end
                ST_DRAIN: begin
                    if (drain == '0) begin
                        state <= ST_DONE;
                    end else begin
                        drain <= drain - DW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Markers describe the pair whose address is on the bus this cycle
    assign issue.valid = rd_en_r;
    assign issue.first = rd_en_r && (tap == '0);
    assign issue.last  = rd_en_r && tap_end;

    sideband_delay #(
        .DEPTH (ROM_LAT + 1)
    ) u_sb (
        .clk       (clk),
        .rstn      (rstn),
        .d         (issue),
        .q         (sb_q),
        .pre_valid (cap)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_a_r <= '0;
            data_b_r <= '0;
        end else if (cap) begin
            data_a_r <= bus.rdata_a;
            data_b_r <= bus.rdata_b;
        end
    end

    assign bus.rd_en     = rd_en_r;
    assign bus.addr_a    = addr_a_r;
    assign bus.addr_b    = addr_b_r;
    assign bus.mac_dataa = data_a_r;
    assign bus.mac_datab = data_b_r;
    assign bus.mac_valid = sb_q.valid;
    assign bus.mac_first = sb_q.first;
    assign bus.mac_last  = sb_q.last;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: two parameterisations, ROM models,
// directed jobs then random jobs checked against a formula-based model.
module tb_mac_operand_feeder;

    import mac_operand_feeder_pkg::*;

    typedef struct packed {
        logic       rd;
        logic [9:0] aa;
        logic [9:0] ab;
        logic [8:0] da;
        logic [8:0] db;
        logic       v;
        logic       f;
        logic       l;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   sel = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mac_operand_feeder_if f0 ();
    mac_operand_feeder_if f1 ();

    mac_operand_feeder #(
        .TAPS (9), .STRIDE (1), .ROM_LAT (1)
    ) u0 (
        .clk (clk), .rstn (rstn), .bus (f0.master)
    );

    mac_operand_feeder #(
        .TAPS (1), .STRIDE (3), .ROM_LAT (2)
    ) u1 (
        .clk (clk), .rstn (rstn), .bus (f1.master)
    );

    logic signed [8:0] rom_a [1024];
    logic signed [8:0] rom_b [1024];
    logic signed [8:0] p1a, p1b;

    always_ff @(posedge clk) begin
        f0.rdata_a <= rom_a[f0.addr_a];
        f0.rdata_b <= rom_b[f0.addr_b];
        p1a        <= rom_a[f1.addr_a];
        p1b        <= rom_b[f1.addr_b];
        f1.rdata_a <= p1a;
        f1.rdata_b <= p1b;
    end

    obs_t ob0, ob1, ob;

    assign ob0 = {f0.rd_en, f0.addr_a, f0.addr_b, f0.mac_dataa,
                  f0.mac_datab, f0.mac_valid, f0.mac_first,
                  f0.mac_last, f0.busy, f0.done};
    assign ob1 = {f1.rd_en, f1.addr_a, f1.addr_b, f1.mac_dataa,
                  f1.mac_datab, f1.mac_valid, f1.mac_first,
                  f1.mac_last, f1.busy, f1.done};
    assign ob = (sel == 1) ? ob1 : ob0;

    task automatic chk(input string tag, input int cyc,
                       input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic st,
                         input int ba, input int bb, input int n);
        if (s == 1) begin
            f1.start  = st;
            f1.base_a = 10'(ba);
            f1.base_b = 10'(bb);
            f1.n_out  = 8'(n);
        end else begin
            f0.start  = st;
            f0.base_a = 10'(ba);
            f0.base_b = 10'(bb);
            f0.n_out  = 8'(n);
        end
    endtask

    // One job; cycle c counts edges after the edge that samples start
    task automatic run_job(input int s, input int ba, input int bb,
                           input int n, input int restart_at,
                           input int abort_at);
        int taps, lat, stride, npair, dc, vi, oi, acc, prod, sum;
        int ea[$];
        int eb[$];
        int esum[$];
        logic [8:0] xa, xb;
        taps   = (s == 1) ? 1 : 9;
        lat    = (s == 1) ? 2 : 1;
        stride = (s == 1) ? 3 : 1;
        npair  = n * taps;
        for (int o = 0; o < n; o++) begin
            sum = 0;
            for (int t = 0; t < taps; t++) begin
                ea.push_back((ba + o * stride + t) % 1024);
                eb.push_back((bb + t) % 1024);
                sum += int'(rom_a[ea[$]]) * int'(rom_b[eb[$]]);
            end
            esum.push_back(sum);
        end
        dc  = (n == 0) ? 1 : npair + lat + 2;
        acc = 0;
        oi  = 0;
        @(negedge clk);
        sel = s;
        drive(s, 1'b1, ba, bb, n);
        for (int c = 1; c <= dc + 3; c++) begin
            @(negedge clk);
            if (c == 1) drive(s, 1'b0, ba, bb, n);
            if (c == restart_at) drive(s, 1'b1, 200, 300, 3);
            if (c == restart_at + 1) drive(s, 1'b0, 200, 300, 3);
            chk("rd_en", c, ob.rd, c <= npair);
            if (c <= npair) begin
                chk("addr_a", c, ob.aa, ea[c-1]);
                chk("addr_b", c, ob.ab, eb[c-1]);
            end
            vi = c - lat - 2;
            chk("mac_valid", c, ob.v, (vi >= 0) && (vi < npair));
            if ((vi >= 0) && (vi < npair)) begin
                xa = rom_a[ea[vi]];
                xb = rom_b[eb[vi]];
                chk("mac_dataa", c, ob.da, xa);
                chk("mac_datab", c, ob.db, xb);
                chk("mac_first", c, ob.f, (vi % taps) == 0);
                chk("mac_last", c, ob.l, (vi % taps) == taps - 1);
                prod = int'($signed(ob.da)) * int'($signed(ob.db));
                acc  = ob.f ? prod : acc + prod;
                if (ob.l && oi < esum.size()) begin
                    chk("mac_sum", c, acc, esum[oi]);
                    oi++;
                end
            end
            chk("busy", c, ob.busy, c <= dc);
            chk("done", c, ob.done, c == dc);
            if (c == abort_at) begin
                rstn = 1'b0;
                #1;
                chk("abort_outs", c, ob, 64'd0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("abort_done", c + k + 1, ob.done, 1'b0);
                    chk("abort_busy", c + k + 1, ob.busy, 1'b0);
                    chk("abort_valid", c + k + 1, ob.v, 1'b0);
                end
                rstn = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        int v;
        for (int i = 0; i < 1024; i++) begin
            v = (i % 200) + 1;
            rom_a[i] = (i % 2 == 1) ? 9'(-v) : 9'(v);
            rom_b[i] = (i < 100) ? -9'sd1 : 9'($urandom);
        end
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_u0", 0, ob0, 64'd0);
        chk("reset_u1", 0, ob1, 64'd0);
        rstn = 1'b1;

        run_job(0, 0, 100, 2, 0, 0);
        run_job(0, 0, 0, 3, 0, 0);
        run_job(0, 5, 7, 0, 0, 0);
        run_job(0, 1020, 50, 1, 5, 0);
        run_job(0, 10, 20, 2, 0, 6);
        run_job(0, 11, 21, 2, 0, 0);
        run_job(1, 30, 40, 4, 0, 0);
        run_job(1, 1022, 1023, 3, 0, 0);

        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 5)), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
